// File: rtl/ww_test_storage_if.sv
// CPU-side request/response bundle for the Whirlwind test storage.
// Handshake: req is sampled only while the responder is idle; busy is high from acceptance through the ack cycle; ack is a one-cycle completion pulse.
interface ww_test_storage_if #(
  parameter int WORD = 16
);
  logic            req;
  logic            we;
  logic [4:0]      addr;
  logic [WORD-1:0] wdata;
  logic            busy;
  logic            ack;
  logic [WORD-1:0] rdata;
  logic            wr_ignored;

  modport master (
    output req, we, addr, wdata,
    input  busy, ack, rdata, wr_ignored
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, rdata, wr_ignored
  );
endinterface

// File: rtl/ww_test_storage.sv
// Test storage responder: 32 read-only toggle-switch words overlaid by five
// plug-addressed flip-flop registers, served with a fixed request-to-ack latency.
module ww_test_storage #(
  parameter int LATENCY = 2,
  parameter int WORD    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_storage_reset,
  input  logic [32*WORD-1:0]   i_sw_ts,
  input  logic [5*WORD-1:0]    i_sw_ff,
  input  logic [24:0]          i_sw_ff_addr,
  ww_test_storage_if.slave     bus,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_busy;
  logic            r_ack;
  logic [WORD-1:0] r_rdata;
  logic            r_wr_ign;
  logic            r_we;
  logic [4:0]      r_addr;
  logic [WORD-1:0] r_wdata;
  logic [WORD-1:0] r_ff [5];

  logic            w_cur_we;
  logic [4:0]      w_cur_addr;
  logic [WORD-1:0] w_cur_wdata;
  logic            w_ff_hit;
  logic [2:0]      w_ff_idx;
  logic [WORD-1:0] w_ff_word;
  logic [WORD-1:0] w_sel;
  logic            w_complete;

  // With LATENCY = 1 the completing edge is the accepting edge, so the
  // request fields come straight from the bus instead of the latches.
  assign w_cur_we    = (r_state == IDLE) ? bus.we    : r_we;
  assign w_cur_addr  = (r_state == IDLE) ? bus.addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? bus.wdata : r_wdata;

  assign w_complete = ((r_state == IDLE) && bus.req && (LATENCY == 1)) ||
                      ((r_state == WAIT) && (r_cnt == 4'd0));

  // Descending scan so the lowest-numbered matching flip-flop wins.
  always_comb begin
    w_ff_hit  = 1'b0;
    w_ff_idx  = 3'd0;
    w_ff_word = '0;
    for (int k = 4; k >= 0; k--) begin
      if (i_sw_ff_addr[5*k +: 5] == w_cur_addr) begin
        w_ff_hit  = 1'b1;
        w_ff_idx  = 3'(k);
        w_ff_word = r_ff[k];
      end
    end
  end

  assign w_sel = w_ff_hit ? w_ff_word : i_sw_ts[int'(w_cur_addr)*WORD +: WORD];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_wr_ign <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      for (int k = 0; k < 5; k++) r_ff[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) r_state <= DONE;
        end
        DONE: begin
          r_busy   <= 1'b0;
          r_ack    <= 1'b0;
          r_wr_ign <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_complete) begin
        r_ack <= 1'b1;
        if (w_cur_we) begin
          r_rdata  <= w_cur_wdata;
          r_wr_ign <= !w_ff_hit;
          for (int k = 0; k < 5; k++) begin
            if (w_ff_hit && (w_ff_idx == 3'(k))) r_ff[k] <= w_cur_wdata;
          end
        end else begin
          r_rdata  <= w_sel;
          r_wr_ign <= 1'b0;
        end
      end

      // Placed last so a preset load overrides a coincident write-back.
      if (i_storage_reset) begin
        for (int k = 0; k < 5; k++) r_ff[k] <= i_sw_ff[k*WORD +: WORD];
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.ack        = r_ack;
  assign bus.rdata      = r_rdata;
  assign bus.wr_ignored = r_wr_ign;
  assign o_state        = r_state;

endmodule

// File: tb/tb_ww_test_storage.sv
// Directed bench for ww_test_storage: expected {wr_ignored, rdata} pairs are
// queued at request time and popped when the ack pulse appears.
module tb_ww_test_storage;
  localparam int LAT = 2;

  logic          clk;
  logic          reset;
  logic          storage_reset;
  logic [511:0]  sw_ts;
  logic [79:0]   sw_ff;
  logic [24:0]   sw_ff_addr;
  logic [1:0]    state;

  logic [15:0]   ts [32];
  logic [15:0]   ff_pre [5];
  logic [4:0]    ff_addr [5];

  logic [16:0]   exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc = 0;

  ww_test_storage_if #(.WORD(16)) bus ();

  ww_test_storage #(.LATENCY(LAT), .WORD(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_storage_reset (storage_reset),
    .i_sw_ts         (sw_ts),
    .i_sw_ff         (sw_ff),
    .i_sw_ff_addr    (sw_ff_addr),
    .bus             (bus.slave),
    .o_state         (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int n = 0; n < 32; n++) sw_ts[n*16 +: 16] = ts[n];
    for (int k = 0; k < 5; k++) begin
      sw_ff[k*16 +: 16]    = ff_pre[k];
      sw_ff_addr[k*5 +: 5] = ff_addr[k];
    end
  end

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic we_i, input logic [4:0] a, input logic [15:0] d,
                       input logic [16:0] exp);
    @(negedge clk);
    bus.req = 1'b1; bus.we = we_i; bus.addr = a; bus.wdata = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    check("busy_set", {16'b0, bus.busy}, 17'd1);
  endtask

  task automatic finish(input string tag);
    logic        seen;
    logic [16:0] exp;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ack) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, {16'b0, seen}, 17'd1);
    if (seen) begin
      check({tag, "_latency"}, 17'(cyc - acc_cyc), 17'(LAT));
      exp = exp_q.pop_front();
      check({tag, "_data"}, {bus.wr_ignored, bus.rdata}, exp);
      @(negedge clk);
      check({tag, "_ack_fall"}, {15'b0, bus.ack, bus.busy}, 17'd0);
      check({tag, "_hold"}, {1'b0, bus.rdata}, {1'b0, exp[15:0]});
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic txn(input string tag, input logic we_i, input logic [4:0] a,
                     input logic [15:0] d, input logic [16:0] exp);
    start(we_i, a, d, exp);
    finish(tag);
  endtask

  task automatic pulse_storage_reset();
    @(negedge clk); storage_reset = 1'b1;
    @(negedge clk); storage_reset = 1'b0;
  endtask

  initial begin
    logic [4:0]  ra;
    logic [15:0] rd;
    reset = 1'b1; storage_reset = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    for (int n = 0; n < 32; n++) ts[n] = 16'($urandom_range(0, 65535));
    ts[26] = 16'o154040;
    ts[3]  = 16'o177777;
    ff_addr[0] = 5'd10; ff_addr[1] = 5'd11; ff_addr[2] = 5'd12;
    ff_addr[3] = 5'd3;  ff_addr[4] = 5'd13;
    for (int k = 0; k < 5; k++) ff_pre[k] = 16'($urandom_range(0, 65535));
    ff_pre[3] = 16'o011111;

    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.wr_ignored, bus.rdata}, 17'd0);
    check("rst_ctrl", {13'b0, state, bus.busy, bus.ack}, 17'd0);
    reset = 1'b0;

    txn("rd_switch26", 1'b0, 5'd26, 16'd0, {1'b0, 16'o154040});

    pulse_storage_reset();
    txn("rd_ff3", 1'b0, 5'd3, 16'd0, {1'b0, 16'o011111});

    txn("wr_ff3", 1'b1, 5'd3, 16'o050000, {1'b0, 16'o050000});
    txn("rd_ff3_new", 1'b0, 5'd3, 16'd0, {1'b0, 16'o050000});
    txn("wr_sw24", 1'b1, 5'd24, 16'o070707, {1'b1, 16'o070707});
    txn("rd_sw24", 1'b0, 5'd24, 16'd0, {1'b0, ts[24]});

    ff_addr[0] = 5'd5; ff_addr[4] = 5'd5;
    ff_pre[0] = 16'o000001; ff_pre[4] = 16'o000004;
    pulse_storage_reset();
    txn("rd_overlap", 1'b0, 5'd5, 16'd0, {1'b0, 16'o000001});

    // Switch word changed while the read is still waiting.
    start(1'b0, 5'd20, 16'd0, {1'b0, 16'o135724});
    @(negedge clk); ts[20] = 16'o135724;
    finish("rd_switch_change");

    // Preset load coincides with the write-back edge.
    start(1'b1, 5'd3, 16'o123456, {1'b0, 16'o123456});
    @(negedge clk);
    @(negedge clk); storage_reset = 1'b1;
    finish("wr_collision");
    storage_reset = 1'b0;
    txn("rd_after_collision", 1'b0, 5'd3, 16'd0, {1'b0, 16'o011111});

    // Async reset while in WAIT aborts the transaction.
    start(1'b0, 5'd26, 16'd0, {1'b0, 16'o154040});
    @(negedge clk);
    check("pre_abort_state", {15'b0, state}, 17'(1));
    reset = 1'b1;
    #1;
    check("abort_outputs", {1'b0, bus.rdata}, 17'd0);
    check("abort_ctrl", {13'b0, state, bus.busy, bus.ack}, 17'd0);
    void'(exp_q.pop_front());
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ack", {16'b0, bus.ack}, 17'd0);
    end
    txn("rd_ff3_cleared", 1'b0, 5'd3, 16'd0, 17'd0);
    pulse_storage_reset();
    txn("rd_ff3_reloaded", 1'b0, 5'd3, 16'd0, {1'b0, 16'o011111});

    for (int i = 0; i < 6; i++) begin
      ra = 5'($urandom_range(16, 31));
      rd = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) txn("rand_wr", 1'b1, ra, rd, {1'b1, rd});
      else                           txn("rand_rd", 1'b0, ra, 16'd0, {1'b0, ts[ra]});
    end

    check("queue_empty", 17'(exp_q.size()), 17'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
